// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the Vram row-memory write arbiter.
package vram_pkg;
   localparam int VRAM_ADDR_W = 9;
   localparam int VRAM_DATA_W = 640;
   localparam int VRAM_ROWS   = 480;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;
endpackage

// File: rtl/vram_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; last_grant advances only on a completed transfer.
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       xfer_i,
   output logic       grant_o
);
   logic last_q, last_d;

   always_comb begin
      grant_o = ~last_q;
      if (valid_i == 2'b01)      grant_o = 1'b0;
      else if (valid_i == 2'b10) grant_o = 1'b1;
      last_d = xfer_i ? grant_o : last_q;
   end

   // Reset to 1 so requester 0 wins the first contested cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) last_q <= 1'b1;
      else       last_q <= last_d;
   end
endmodule

// File: rtl/vram_write_arbiter.sv
// Owns the Vram write port: round-robin between two row writers plus a
// full-screen clear sweep, optionally gated to vertical blanking.
module vram_write_arbiter
   import vram_pkg::*;
#(
   parameter int                ADDR_W      = VRAM_ADDR_W,
   parameter int                DATA_W      = VRAM_DATA_W,
   parameter int                ROWS        = VRAM_ROWS,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
   parameter bit                BLANK_ONLY  = 1'b1
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              v_blank,
   input  logic              clear_start,
   output logic              clear_busy,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_a,
   output logic [DATA_W-1:0] vram_d,
   output logic              addr_err
);
   localparam logic [ADDR_W:0]   ROWS_L   = (ADDR_W+1)'(ROWS);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   d_q, d_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                write_ok, arb_en, grant, xfer, in_range;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;

   assign write_ok   = ~BLANK_ONLY | v_blank;
   // clear_start pre-empts any handshake in the cycle it arrives.
   assign arb_en     = (state_q == ST_ARB) & write_ok & ~clear_start;
   assign req0_ready = arb_en & ~grant;
   assign req1_ready = arb_en & grant;
   assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign sel_addr   = grant ? req1_addr : req0_addr;
   assign sel_data   = grant ? req1_data : req0_data;
   assign in_range   = {1'b0, sel_addr} < ROWS_L;

   rr_arbiter2 u_rr (
      .clk_i   (sys_clk),
      .rst_i   (rst),
      .valid_i ({req1_valid, req0_valid}),
      .xfer_i  (xfer),
      .grant_o (grant)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      a_d     = a_q;
      d_d     = d_q;
      err_d   = err_q;
      case (state_q)
         ST_ARB: begin
            if (clear_start) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else if (xfer) begin
               if (in_range) begin
                  we_d = 1'b1;
                  a_d  = sel_addr;
                  d_d  = sel_data;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            if (write_ok) begin
               we_d  = 1'b1;
               a_d   = cnt_q;
               d_d   = CLEAR_VALUE;
               cnt_d = cnt_q + ADDR_W'(1);
               if (cnt_q == LAST_ROW) state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
      busy_d = (state_d == ST_CLEAR);
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ARB;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         a_q     <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         a_q     <= a_d;
         d_q     <= d_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign vram_we    = we_q;
   assign vram_a     = a_q;
   assign vram_d     = d_q;
   assign clear_busy = busy_q;
   assign addr_err   = err_q;
endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Owns the single write port of the Vram row memory (9-bit row address, 640-bit row data).
- Arbitrates two row-write requesters onto that port, for example the Graphic engine and a future text/sprite engine.
- Provides a built-in full-screen clear sequencer.
- Optionally restricts writes to vertical blanking, so the GPU scan-out read port never sees a half-updated frame.

Parameters:
- ADDR_W, 9, row address width
- DATA_W, 640, row data width (one bit per pixel)
- ROWS, 480, number of valid rows; addresses ROWS..2^ADDR_W-1 are out of range
- CLEAR_VALUE, 0, DATA_W-bit value written to every row by a clear
- BLANK_ONLY, 1, 1 = writes and clear steps are issued only while v_blank=1; 0 = issued at any time

Ports:
- sys_clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-high reset
- v_blank  in  1  vertical-blank indicator, already synchronous to sys_clk
- clear_start  in  1  one-cycle pulse requesting a full clear
- clear_busy  out  1  high while a clear is in progress
- req0_valid  in  1  requester 0 has a row write pending
- req0_ready  out  1  requester 0 write accepted this cycle
- req0_addr  in  ADDR_W  requester 0 row address
- req0_data  in  DATA_W  requester 0 row data
- req1_valid, req1_ready, req1_addr, req1_data: same as requester 0, for requester 1
- vram_we  out  1  Vram write enable
- vram_a  out  ADDR_W  Vram write address
- vram_d  out  DATA_W  Vram write data
- addr_err  out  1  sticky flag: an out-of-range write was dropped

Behaviour:
- Reset values (asynchronous): state=ARB, vram_we=0, vram_a=0, vram_d=0, clear_busy=0, addr_err=0, last_grant=1 (requester 0 wins first).
- write_ok = (BLANK_ONLY==0) | v_blank.
- States:
  - ARB: serves requesters.
  - CLEAR: sweeps all rows.
- ARB, grant selection:
  - only one requester valid: grant it.
  - both valid: grant the one not equal to last_grant.
- ARB, ready and transfer:
  - reqN_ready = (state==ARB) & write_ok & granted==N & ~clear_start. This is combinational.
  - A transfer occurs when valid & ready.
  - last_grant updates to N on each transfer.
- Write timing:
  - On a transfer with addr < ROWS: the next cycle drives vram_we=1 with vram_a/vram_d equal to the captured addr/data. Latency is 1 cycle.
  - All vram_* outputs are registered.
  - With no transfer, vram_we=0 and vram_a/vram_d hold their last values.
- Out-of-range address (addr >= ROWS): the handshake still completes (ready asserted), the write is dropped (vram_we=0), and addr_err is set until rst.
- Requesters must hold valid/addr/data stable until ready. The arbiter does not check this.
- ARB -> CLEAR:
  - clear_start=1 in ARB moves to CLEAR on the next cycle.
  - clear_start has priority over requests in the same cycle: no ready is asserted that cycle.
  - clear_busy=1 from that next cycle.
  - Row counter is reset to 0.
- CLEAR:
  - Each cycle with write_ok=1: vram_we=1, vram_a=counter, vram_d=CLEAR_VALUE (registered, same 1-cycle latency); counter increments.
  - write_ok=0: the clear pauses, vram_we=0, and the counter holds.
  - After row ROWS-1 is issued: return to ARB and drop clear_busy on the same edge.
  - All readys are 0 throughout CLEAR.
  - clear_start during CLEAR is ignored (no restart, no queuing).
- Duration: a clear takes exactly ROWS write_ok cycles (480 with the defaults).
- Reset mid-clear or mid-write aborts immediately. No partial state survives, and the remaining rows are not cleared.
- Counter width is ADDR_W. It never wraps, because ROWS <= 2^ADDR_W.

Decomposition:
- Shared package vram_pkg: constants VRAM_ADDR_W=9, VRAM_DATA_W=640, VRAM_ROWS=480, and the state encoding (ST_ARB, ST_CLEAR).
- One natural sub-module: rr_arbiter2, a two-way round-robin grant with a last_grant register and a grant-on-transfer update. The FSM, clear counter and output registers stay in the top block.

Test Plan:
- BLANK_ONLY=0, req0 writes addr 5, data all-ones -> req0_ready=1 that cycle; next cycle vram_we=1, vram_a=5, vram_d all-ones; following cycle vram_we=0.
- Both requesters valid continuously with distinct addresses (req0 addr 10, req1 addr 20), 4 transfers after reset -> grant order 0,1,0,1; vram_a sequence 10,20,10,20.
- BLANK_ONLY=1, v_blank=0, req1 valid -> req1_ready stays 0 and no vram_we. Raise v_blank -> transfer in the same cycle, write one cycle later.
- clear_start pulse with req0 valid, BLANK_ONLY=0 -> req0_ready=0 that cycle; clear_busy high for 480 cycles; vram_a runs 0..479 with data 0; then req0 is served.
- req0 addr 480 -> handshake completes, no vram_we, addr_err=1 and stays set. Later valid writes still complete normally.
- Assert rst at clear row 100 -> clear_busy, vram_we and addr_err are 0 immediately. After release: state ARB, no further clear writes.
